// File: rtl/dispatch_pkg.sv
// Shared constants and control-state encoding for the demux dispatcher.
package dispatch_pkg;

    localparam int SEL_W     = 2;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Purpose: DEPTH-entry circular buffer with occupancy count for the dispatcher.
// Latency: write at edge N is readable at the head after edge N (registered storage).
// Backpressure: none internally; caller must never push when full or pop when empty.
module dispatch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] cnt;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign level = cnt;

endmodule

// File: rtl/demux_dispatcher.sv
// Purpose: buffers {data,dest} items and drives a 1:4 demux select/data from the head; DISPATCH_RR_EN selects round-robin sel.
// Latency: 1 cycle from push into an empty FIFO to presentation on sel/dout.
// Backpressure: in_ready drops when FULL; head held stable while out_valid & !out_ready.
module demux_dispatcher #(
    parameter  int DEPTH = dispatch_pkg::DEPTH_DEF,
    parameter  int SEL_W = dispatch_pkg::SEL_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic [SEL_W-1:0] in_dest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic [LW-1:0]    level
);

`ifdef DISPATCH_RR_EN
    localparam int W = 1;
`else
    localparam int W = 1 + SEL_W;
`endif

    dispatch_pkg::state_t state_q;
    dispatch_pkg::state_t state_d;

    logic             push;
    logic             pop;
    logic [W-1:0]     wdata;
    logic [W-1:0]     rdata;
    logic [SEL_W-1:0] head_sel;
    logic             head_data;
    logic [SEL_W-1:0] sel_hold;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head_data = rdata[0];

`ifdef DISPATCH_RR_EN
    logic [SEL_W-1:0] rr_q;
    logic             unused_dest;

    assign wdata       = in_data;
    assign head_sel    = rr_q;
    assign unused_dest = ^in_dest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rr_q <= '0;
        else if (pop) rr_q <= rr_q + 1'b1;
    end
`else
    assign wdata    = {in_dest, in_data};
    assign head_sel = rdata[W-1:1];
`endif

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= dispatch_pkg::EMPTY;
        else     state_q <= state_d;
    end

    // No push can occur in FULL, so push+pop there collapses to a pop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            dispatch_pkg::EMPTY: begin
                if (push) state_d = (DEPTH == 1) ? dispatch_pkg::FULL : dispatch_pkg::PARTIAL;
            end
            dispatch_pkg::PARTIAL: begin
                if (push && !pop && level == LW'(DEPTH - 1))
                    state_d = dispatch_pkg::FULL;
                else if (pop && !push && level == LW'(1))
                    state_d = dispatch_pkg::EMPTY;
            end
            dispatch_pkg::FULL: begin
                if (pop) state_d = dispatch_pkg::PARTIAL;
            end
            default: state_d = dispatch_pkg::EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != dispatch_pkg::FULL);
        out_valid = (state_q != dispatch_pkg::EMPTY);
        sel       = out_valid ? head_sel : sel_hold;
        dout      = out_valid & head_data;
    end

    // Remembers the last presented select so an idle demux keeps its route.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_hold <= '0;
        else     sel_hold <= sel;
    end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed vector bench for demux_dispatcher: table-driven handshake vectors plus async-reset and round-robin sequences.
module tb_demux_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_data;
    logic [1:0] in_dest;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] sel;
    logic       dout;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    demux_dispatcher #(.DEPTH(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .dout      (dout),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       d;
        logic [1:0] dest;
        logic       ordy;
        int         lvl;
        logic       ir;
        logic       ov;
        logic [1:0] s;
        logic       dt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic iv, input logic d, input logic [1:0] dest,
                                input logic ordy, input int lvl, input logic ir,
                                input logic ov, input logic [1:0] s, input logic dt);
        vec_t v;
        v.iv = iv; v.d = d; v.dest = dest; v.ordy = ordy;
        v.lvl = lvl; v.ir = ir; v.ov = ov; v.s = s; v.dt = dt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lvl, input int ir, input int ov,
                           input int s, input int dt);
        chk({tag, ".level"},     int'(level),     lvl);
        chk({tag, ".in_ready"},  int'(in_ready),  ir);
        chk({tag, ".out_valid"}, int'(out_valid), ov);
        chk({tag, ".sel"},       int'(sel),       s);
        chk({tag, ".dout"},      int'(dout),      dt);
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic iv, input logic d, input logic [1:0] dest, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_dest   = dest;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_dest = 2'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef DISPATCH_RR_EN
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 2'd3, 1'b0);
            chk($sformatf("rr%0d.out_valid", k), int'(out_valid), 1);
            chk($sformatf("rr%0d.sel", k), int'(sel), k % 4);
            chk($sformatf("rr%0d.dout", k), int'(dout), 1);
            step(1'b0, 1'b0, 2'd0, 1'b1);
            chk($sformatf("rr%0d.popped_valid", k), int'(out_valid), 0);
            chk($sformatf("rr%0d.popped_level", k), int'(level), 0);
        end
`else
        //           iv d  dest ordy  lvl ir ov sel dout
        vt.push_back(mk(1, 1, 2, 1,   1, 1, 1, 2, 1));
        vt.push_back(mk(0, 0, 0, 1,   0, 1, 0, 2, 0));
        vt.push_back(mk(1, 1, 0, 0,   1, 1, 1, 0, 1));
        vt.push_back(mk(1, 0, 1, 0,   2, 1, 1, 0, 1));
        vt.push_back(mk(1, 1, 2, 0,   3, 1, 1, 0, 1));
        vt.push_back(mk(1, 0, 3, 0,   4, 0, 1, 0, 1));
        vt.push_back(mk(1, 1, 1, 0,   4, 0, 1, 0, 1));
        vt.push_back(mk(0, 0, 0, 1,   3, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,   3, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 1,   2, 1, 1, 2, 1));
        vt.push_back(mk(0, 0, 0, 0,   2, 1, 1, 2, 1));
        vt.push_back(mk(0, 0, 0, 1,   1, 1, 1, 3, 0));
        vt.push_back(mk(0, 0, 0, 0,   1, 1, 1, 3, 0));
        vt.push_back(mk(1, 1, 1, 0,   2, 1, 1, 3, 0));
        vt.push_back(mk(1, 0, 2, 1,   2, 1, 1, 1, 1));
        vt.push_back(mk(1, 1, 0, 0,   3, 1, 1, 1, 1));
        vt.push_back(mk(1, 0, 3, 0,   4, 0, 1, 1, 1));
        vt.push_back(mk(1, 1, 2, 1,   3, 1, 1, 2, 0));
        vt.push_back(mk(0, 0, 0, 1,   2, 1, 1, 0, 1));
        vt.push_back(mk(0, 0, 0, 1,   1, 1, 1, 3, 0));
        vt.push_back(mk(0, 0, 0, 1,   0, 1, 0, 3, 0));
        vt.push_back(mk(0, 0, 0, 1,   0, 1, 0, 3, 0));

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].iv, vt[i].d, vt[i].dest, vt[i].ordy);
            chk_all($sformatf("v%0d", i), vt[i].lvl, int'(vt[i].ir), int'(vt[i].ov),
                    int'(vt[i].s), int'(vt[i].dt));
        end

        // Asynchronous reset at level 3 must clear outputs before the next edge.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd1, 1'b0);
        chk("pre_rst.level", int'(level), 3);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 1, 0, 0, 0);
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 2'd0, 1'b1);
        chk_all("post_rst_idle", 0, 1, 0, 0, 0);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        chk_all("post_rst_push", 1, 1, 1, 2, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_dispatcher.md
DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter SEL_W, default 2, select width driving the 1:4 demux.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, upstream item present.
REQ-006 SHALL have port in_ready, output, 1, block can accept an item this cycle.
REQ-007 SHALL have port in_data, input, 1, data bit to route.
REQ-008 SHALL have port in_dest, input, SEL_W, destination channel 0..3.
REQ-009 SHALL have port out_valid, output, 1, head item presented to the demux.
REQ-010 SHALL have port out_ready, input, 1, downstream consumed presented item.
REQ-011 SHALL have port sel, output, SEL_W, demux select.
REQ-012 SHALL have port dout, output, 1, demux data input.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-014 SHALL buffer {in_data, in_dest} in a DEPTH-entry FIFO; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-015 SHALL drive in_ready = (level < DEPTH); there is no bypass, so a push while full is impossible.
REQ-016 SHALL drive out_valid = (level != 0); sel/dout = head entry, from registered storage only.
REQ-017 SHALL present an item pushed at edge N on sel/dout at edge N+1 when the FIFO was empty (1-cycle latency).
REQ-018 SHALL, when empty, hold sel at its last presented value and force dout = 0, so all demux outputs are 0.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; level changes by +1 on push only, -1 on pop only, and 0 on simultaneous push+pop.
REQ-020 SHALL keep control FSM states EMPTY (level 0), PARTIAL (0<level<DEPTH), and FULL (level DEPTH); transitions follow level after each edge; FULL->EMPTY is unreachable in one cycle unless DEPTH=1.
REQ-021 SHALL treat a simultaneous push+pop in FULL as pop only (in_ready=0), giving a next state of PARTIAL.
REQ-022 SHALL hold out_valid, sel and dout stable while out_valid & !out_ready.

Reset
REQ-023 SHALL on rst: pointers=0, level=0, state EMPTY, in_ready=1, out_valid=0, sel=0, dout=0.
REQ-024 SHALL discard all buffered items on rst asserted mid-operation; no pop is reported for discarded items.

Configuration
REQ-025 SHALL, with DISPATCH_RR_EN defined, ignore in_dest (not stored) and set sel from an internal round-robin counter: reset 0, +1 on each pop, wrapping 3->0.
REQ-026 SHALL, without DISPATCH_RR_EN, take sel from the stored in_dest of the head entry.

Structure
REQ-027 SHALL place SEL_W, the default DEPTH and the FSM state enum (EMPTY/PARTIAL/FULL) in shared package dispatch_pkg.
REQ-028 SHALL implement storage and pointers in one sub-module, dispatch_fifo; demux_dispatcher holds the FSM, handshake and RR counter.

Verification
REQ-029 SHALL cover single item: push {data=1,dest=2} at edge 1, out_ready=1 -> cycle 2 sel=2, dout=1, out_valid=1; cycle 3 out_valid=0, dout=0, sel=2.
REQ-030 SHALL cover fill: 5 consecutive pushes with out_ready=0 -> 4 accepted, level=4, in_ready=0 on the 5th, state FULL.
REQ-031 SHALL cover backpressure: FULL with dests 0,1,2,3, out_ready toggling 1/0 -> sel sequence 0,1,2,3 in order, each held while out_ready=0.
REQ-032 SHALL cover simultaneous push+pop at level 2 -> level stays 2; with level 4 and push+pop asserted -> level 3.
REQ-033 SHALL cover rst asserted asynchronously at level 3 -> level=0, out_valid=0, in_ready=1 immediately, before the next clk edge.
REQ-034 SHALL cover DISPATCH_RR_EN: 5 pushes with dest=3 all popped -> sel sequence 0,1,2,3,0.
